// File: rtl/bsg_dmc_ui_master.sv
// bsg_dmc_ui_master: turns one cache-line request into app_* UI transactions.
// Write lines are sent as burst_len_lp data beats, followed by the write command.
// Reads send the command, collect the returned beats into one line and present
// that line as a single response.
// Optional feature, enabled by defining BSG_DMC_UI_MASTER_WR_ACK_EN: a write also
// ends with a response whose data is all zeros.
module bsg_dmc_ui_master #(
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 32,
    parameter int burst_data_width_p = 128,
    localparam int burst_len_lp        = burst_data_width_p / ui_data_width_p,
    localparam int ui_mask_width_lp    = ui_data_width_p / 8,
    localparam int burst_mask_width_lp = burst_data_width_p / 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           init_calib_complete_i,
    input  logic                           req_v_i,
    input  logic [2:0]                     req_cmd_i,
    input  logic [ui_addr_width_p-1:0]     req_addr_i,
    input  logic [burst_data_width_p-1:0]  req_data_i,
    input  logic [burst_mask_width_lp-1:0] req_mask_i,
    output logic                           req_ready_o,
    output logic                           resp_v_o,
    output logic [burst_data_width_p-1:0]  resp_data_o,
    input  logic                           resp_yumi_i,
    output logic [ui_addr_width_p-1:0]     app_addr_o,
    output logic [2:0]                     app_cmd_o,
    output logic                           app_en_o,
    input  logic                           app_rdy_i,
    output logic                           app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]     app_wdf_data_o,
    output logic [ui_mask_width_lp-1:0]    app_wdf_mask_o,
    output logic                           app_wdf_end_o,
    input  logic                           app_wdf_rdy_i,
    input  logic                           app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]     app_rd_data_i,
    input  logic                           app_rd_data_end_i,
    output logic                           error_o
);

    localparam int cnt_w_lp = (burst_len_lp > 1) ? $clog2(burst_len_lp) : 1;
    localparam logic [2:0] cmd_write_lp = 3'd0;
    localparam logic [2:0] cmd_read_lp  = 3'd1;

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA, RESP
    } state_e;

    state_e                                           r_state, w_next_state;
    logic [cnt_w_lp-1:0]                              r_cnt;
    logic [ui_addr_width_p-1:0]                       r_addr;
    logic [burst_len_lp-1:0][ui_data_width_p-1:0]     r_line;
    logic [burst_len_lp-1:0][ui_mask_width_lp-1:0]    r_mask;
    logic                                             r_error;
    logic                                             w_accept;
    logic                                             w_beat_last;

    assign w_beat_last = (r_cnt == cnt_w_lp'(burst_len_lp - 1));
    assign w_accept    = req_v_i & req_ready_o;

    // Next-state decode for the transaction sequencer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_cmd_i == cmd_write_lp)     w_next_state = WR_DATA;
                    else if (req_cmd_i == cmd_read_lp) w_next_state = RD_CMD;
                end
            end
            WR_DATA: if (app_wdf_rdy_i && w_beat_last) w_next_state = WR_CMD;
`ifdef BSG_DMC_UI_MASTER_WR_ACK_EN
            WR_CMD:  if (app_rdy_i) w_next_state = RESP;
`else
            WR_CMD:  if (app_rdy_i) w_next_state = IDLE;
`endif
            RD_CMD:  if (app_rdy_i) w_next_state = RD_DATA;
            RD_DATA: if (app_rd_data_valid_i && w_beat_last) w_next_state = RESP;
            RESP:    if (resp_yumi_i) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded purely from registered state; only req_ready_o looks at inputs.
    always_comb begin
        req_ready_o    = (r_state == IDLE) & init_calib_complete_i & ~reset_i;
        app_en_o       = (r_state == WR_CMD) || (r_state == RD_CMD);
        app_cmd_o      = (r_state == RD_CMD) ? cmd_read_lp : cmd_write_lp;
        app_addr_o     = r_addr;
        app_wdf_wren_o = (r_state == WR_DATA);
        app_wdf_data_o = r_line[r_cnt];
        app_wdf_mask_o = r_mask[r_cnt];
        app_wdf_end_o  = (r_state == WR_DATA) && w_beat_last;
        resp_v_o       = (r_state == RESP);
        resp_data_o    = r_line;
        error_o        = r_error;
    end

    // State, beat counter, line/mask capture and sticky error tracking.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_mask  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= req_addr_i;
                        r_line <= req_data_i;
                        r_mask <= req_mask_i;
                        r_cnt  <= '0;
                        if (req_cmd_i != cmd_write_lp && req_cmd_i != cmd_read_lp)
                            r_error <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (app_wdf_rdy_i)
                        r_cnt <= w_beat_last ? '0 : r_cnt + 1'b1;
                end
`ifdef BSG_DMC_UI_MASTER_WR_ACK_EN
                // Write acknowledgement carries no data.
                WR_CMD: if (app_rdy_i) r_line <= '0;
`endif
                RD_DATA: begin
                    if (app_rd_data_valid_i) begin
                        r_line[r_cnt] <= app_rd_data_i;
                        r_cnt         <= w_beat_last ? '0 : r_cnt + 1'b1;
                        // End flag must coincide exactly with the final beat.
                        if (app_rd_data_end_i != w_beat_last)
                            r_error <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Read data nobody asked for is dropped but remembered as an error.
            if (app_rd_data_valid_i && r_state != RD_DATA)
                r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_dmc_ui_master.sv
// Scoreboard bench for bsg_dmc_ui_master: stimulus pushes expected UI events,
// a negedge monitor pops and compares every handshake the DUT completes.
module tb_bsg_dmc_ui_master;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int BW = 128;
    localparam int MW = BW / 8;

    typedef enum logic [1:0] {EV_WDF, EV_CMD, EV_RESP} kind_e;
    typedef struct {
        kind_e          kind;
        logic [127:0]   data;
        logic [15:0]    mask;
        logic [31:0]    aux;
    } ev_t;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b1;
    logic                init_calib_complete_i = 1'b1;
    logic                req_v_i = 1'b0;
    logic [2:0]          req_cmd_i = '0;
    logic [AW-1:0]       req_addr_i = '0;
    logic [BW-1:0]       req_data_i = '0;
    logic [MW-1:0]       req_mask_i = '0;
    logic                req_ready_o;
    logic                resp_v_o;
    logic [BW-1:0]       resp_data_o;
    logic                resp_yumi_i = 1'b0;
    logic [AW-1:0]       app_addr_o;
    logic [2:0]          app_cmd_o;
    logic                app_en_o;
    logic                app_rdy_i = 1'b1;
    logic                app_wdf_wren_o;
    logic [DW-1:0]       app_wdf_data_o;
    logic [DW/8-1:0]     app_wdf_mask_o;
    logic                app_wdf_end_o;
    logic                app_wdf_rdy_i = 1'b1;
    logic                app_rd_data_valid_i = 1'b0;
    logic [DW-1:0]       app_rd_data_i = '0;
    logic                app_rd_data_end_i = 1'b0;
    logic                error_o;

    int  n_vec = 0;
    int  n_err = 0;
    ev_t sb[$];

    bsg_dmc_ui_master #(
        .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_data_width_p(BW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .init_calib_complete_i(init_calib_complete_i),
        .req_v_i(req_v_i), .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_ready_o(req_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
        .app_rdy_i(app_rdy_i), .app_wdf_wren_o(app_wdf_wren_o),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input kind_e k, input logic [127:0] d, input logic [15:0] m, input logic [31:0] a);
        ev_t e;
        e.kind = k; e.data = d; e.mask = m; e.aux = a;
        sb.push_back(e);
    endtask

    task automatic compare(input kind_e k, input logic [127:0] d, input logic [15:0] m, input logic [31:0] a);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", {126'd0, k}, 128'hFFFF);
        end else begin
            e = sb.pop_front();
            check("event_kind", {126'd0, k}, {126'd0, e.kind});
            check("event_data", d, e.data);
            check("event_mask", {112'd0, m}, {112'd0, e.mask});
            check("event_aux", {96'd0, a}, {96'd0, e.aux});
        end
    endtask

    // Monitor: every completed handshake is compared against the scoreboard head.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (app_wdf_wren_o && app_wdf_rdy_i)
                compare(EV_WDF, {96'd0, app_wdf_data_o}, {12'd0, app_wdf_mask_o}, {31'd0, app_wdf_end_o});
            if (app_en_o && app_rdy_i)
                compare(EV_CMD, {100'd0, app_addr_o}, 16'd0, {29'd0, app_cmd_o});
            if (resp_v_o && resp_yumi_i)
                compare(EV_RESP, resp_data_o, 16'd0, 32'd0);
        end
    end

    // Present a request and hold it until accepted; returns just after the accepting edge.
    task automatic do_req(input logic [2:0] cmd, input logic [AW-1:0] addr,
                          input logic [BW-1:0] data, input logic [MW-1:0] mask);
        int n = 0;
        req_cmd_i = cmd; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
        req_v_i = 1'b1;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        check("req_accept", {127'd0, req_ready_o}, 128'd1);
        tick();
        req_v_i = 1'b0;
    endtask

    task automatic finish_resp();
        int n = 0;
        @(negedge clk_i);
        while (!resp_v_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("resp_wait", {127'd0, resp_v_o}, 128'd1);
        tick();
        resp_yumi_i = 1'b1;
        tick();
        resp_yumi_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
    endtask

    // Four read beats base+0..base+3, one idle cycle between beats, end flag on end_idx.
    task automatic rd_beats(input logic [DW-1:0] base, input int end_idx);
        for (int i = 0; i < 4; i++) begin
            app_rd_data_valid_i = 1'b1;
            app_rd_data_i       = base + DW'(i);
            app_rd_data_end_i   = (i == end_idx);
            if (i == 3) begin
                @(negedge clk_i);
                check("resp_not_early", {127'd0, resp_v_o}, 128'd0);
            end
            tick();
            app_rd_data_valid_i = 1'b0;
            app_rd_data_end_i   = 1'b0;
            if (i == 3) begin
                @(negedge clk_i);
                check("resp_latency", {127'd0, resp_v_o}, 128'd1);
            end else begin
                if (i == end_idx) begin
                    @(negedge clk_i);
                    check("error_early_end", {127'd0, error_o}, 128'd1);
                end
                tick();
            end
        end
    endtask

    localparam logic [BW-1:0] W1 = 128'h44444444_33333333_22222222_11111111;

    initial begin
        int en_cycles;
        int n;

        // Reset state
        repeat (2) tick();
        @(negedge clk_i);
        check("rst_req_ready", {127'd0, req_ready_o}, 128'd0);
        check("rst_resp_v", {127'd0, resp_v_o}, 128'd0);
        check("rst_app_en", {127'd0, app_en_o}, 128'd0);
        check("rst_wren", {127'd0, app_wdf_wren_o}, 128'd0);
        check("rst_wdf_end", {127'd0, app_wdf_end_o}, 128'd0);
        check("rst_error", {127'd0, error_o}, 128'd0);
        check("rst_addr", {100'd0, app_addr_o}, 128'd0);
        tick();
        reset_i = 1'b0;
        tick();

        // 1: plain write, mask 0
        push(EV_WDF, 128'h11111111, 16'h0, 32'd0);
        push(EV_WDF, 128'h22222222, 16'h0, 32'd0);
        push(EV_WDF, 128'h33333333, 16'h0, 32'd0);
        push(EV_WDF, 128'h44444444, 16'h0, 32'd1);
        push(EV_CMD, 128'h40, 16'h0, 32'd0);
`ifdef BSG_DMC_UI_MASTER_WR_ACK_EN
        push(EV_RESP, 128'd0, 16'h0, 32'd0);
        do_req(3'd0, 28'h0000040, W1, 16'h0);
        finish_resp();
`else
        do_req(3'd0, 28'h0000040, W1, 16'h0);
`endif
        drain();
        tick();

        // 2: same write with wdf stall on beat 1 and cmd stall; mask F0A5
        push(EV_WDF, 128'h11111111, 16'h5, 32'd0);
        push(EV_WDF, 128'h22222222, 16'hA, 32'd0);
        push(EV_WDF, 128'h33333333, 16'h0, 32'd0);
        push(EV_WDF, 128'h44444444, 16'hF, 32'd1);
        push(EV_CMD, 128'h40, 16'h0, 32'd0);
`ifdef BSG_DMC_UI_MASTER_WR_ACK_EN
        push(EV_RESP, 128'd0, 16'h0, 32'd0);
`endif
        app_rdy_i = 1'b0;
        do_req(3'd0, 28'h0000040, W1, 16'hF0A5);
        tick();
        app_wdf_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_beat1_data", {96'd0, app_wdf_data_o}, 128'h22222222);
            check("stall_beat1_wren", {127'd0, app_wdf_wren_o}, 128'd1);
            tick();
        end
        app_wdf_rdy_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!app_en_o && n < 20) begin
            tick();
            @(negedge clk_i);
            n++;
        end
        en_cycles = app_en_o ? 1 : 0;
        tick();
        @(negedge clk_i);
        if (app_en_o) en_cycles++;
        tick();
        app_rdy_i = 1'b1;
        @(negedge clk_i);
        if (app_en_o) en_cycles++;
        tick();
        @(negedge clk_i);
        check("app_en_released", {127'd0, app_en_o}, 128'd0);
        check("app_en_cycles", 128'(en_cycles), 128'd3);
`ifdef BSG_DMC_UI_MASTER_WR_ACK_EN
        tick();
        finish_resp();
`endif
        drain();
        tick();

        // 3: read 0x80 with gapped beats
        push(EV_CMD, 128'h80, 16'h0, 32'd1);
        push(EV_RESP, 128'h000000A3_000000A2_000000A1_000000A0, 16'h0, 32'd0);
        do_req(3'd1, 28'h80, '0, '0);
        tick();
        tick();
        rd_beats(32'hA0, 3);
        tick();
        @(negedge clk_i);
        check("resp_held", {127'd0, resp_v_o}, 128'd1);
        check("resp_held_data", resp_data_o, 128'h000000A3_000000A2_000000A1_000000A0);
        check("read_no_error", {127'd0, error_o}, 128'd0);
        finish_resp();
        drain();

        // 4: read with early end flag on beat 2
        push(EV_CMD, 128'h100, 16'h0, 32'd1);
        push(EV_RESP, 128'h000000B3_000000B2_000000B1_000000B0, 16'h0, 32'd0);
        do_req(3'd1, 28'h100, '0, '0);
        tick();
        tick();
        @(negedge clk_i);
        check("error_before_early_end", {127'd0, error_o}, 128'd0);
        tick();
        rd_beats(32'hB0, 2);
        finish_resp();
        @(negedge clk_i);
        check("idle_after_err_read", {127'd0, req_ready_o}, 128'd1);
        drain();

        // 5: calibration not complete blocks requests
        init_calib_complete_i = 1'b0;
        req_cmd_i = 3'd1; req_addr_i = 28'h200; req_v_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("nocal_ready", {127'd0, req_ready_o}, 128'd0);
            check("nocal_en", {127'd0, app_en_o | app_wdf_wren_o}, 128'd0);
            tick();
        end
        push(EV_CMD, 128'h200, 16'h0, 32'd1);
        push(EV_RESP, 128'h000000C3_000000C2_000000C1_000000C0, 16'h0, 32'd0);
        init_calib_complete_i = 1'b1;
        @(negedge clk_i);
        check("cal_accept_same_cycle", {127'd0, req_ready_o}, 128'd1);
        tick();
        req_v_i = 1'b0;
        tick();
        tick();
        rd_beats(32'hC0, 3);
        finish_resp();
        drain();

        // 6: reset during write beat 2, then a clean read
        push(EV_WDF, 128'h11111111, 16'h0, 32'd0);
        push(EV_WDF, 128'h22222222, 16'h0, 32'd0);
        do_req(3'd0, 28'h40, W1, '0);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("rst_mid_wren", {127'd0, app_wdf_wren_o}, 128'd0);
        check("rst_mid_en", {127'd0, app_en_o}, 128'd0);
        tick();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_idle", {127'd0, req_ready_o}, 128'd1);
        check("rst_mid_error_clr", {127'd0, error_o}, 128'd0);
        drain();
        tick();
        push(EV_CMD, 128'h300, 16'h0, 32'd1);
        push(EV_RESP, 128'h000000D3_000000D2_000000D1_000000D0, 16'h0, 32'd0);
        do_req(3'd1, 28'h300, '0, '0);
        tick();
        tick();
        rd_beats(32'hD0, 3);
        finish_resp();
        drain();
        @(negedge clk_i);
        check("final_no_error", {127'd0, error_o}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
